// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event bundle between scanner and its consumer.
// The scanner side is the master: it strobes rows and publishes events.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row,
        output key_code,
        output key_valid,
        output key_held,
        input  col
    );

    modport slave (
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held,
        output col
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotating active-low row strobe, frame-level
// debounce, one key_valid pulse per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input logic             clk,
    input logic             rst,
    keypad_scanner_if.master bus
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [DW-1:0] dwell;
    logic [3:0]    row_q;
    logic          acc_found;
    logic [3:0]    acc_code;

    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [3:0]    code_q;
    logic          valid_q;
    logic          held_q;

    logic          tc;
    logic          row_ok;
    logic [1:0]    row_idx;
    logic [3:0]    row_next;
    logic          col_hit;
    logic [1:0]    col_idx;
    logic          hit;
    logic [3:0]    cur_code;
    logic          frame_done;
    logic          frame_found;
    logic [3:0]    frame_code;
    logic [CW-1:0] cnt_inc;

    assign tc = (dwell == DWELL_MAX);

    always_comb begin
        row_ok   = 1'b1;
        row_idx  = 2'd0;
        row_next = 4'b1110;
        case (row_q)
            4'b1110: begin
                row_idx  = 2'd0;
                row_next = 4'b1101;
            end
            4'b1101: begin
                row_idx  = 2'd1;
                row_next = 4'b1011;
            end
            4'b1011: begin
                row_idx  = 2'd2;
                row_next = 4'b0111;
            end
            4'b0111: begin
                row_idx  = 2'd3;
                row_next = 4'b1110;
            end
            default: row_ok = 1'b0;
        endcase
    end

    // Several columns may be low at once; the lowest index wins.
    always_comb begin
        col_hit = 1'b1;
        col_idx = 2'd0;
        priority case (1'b1)
            !col_s2[0]: col_idx = 2'd0;
            !col_s2[1]: col_idx = 2'd1;
            !col_s2[2]: col_idx = 2'd2;
            !col_s2[3]: col_idx = 2'd3;
            default:    col_hit = 1'b0;
        endcase
    end

    assign hit         = row_ok && col_hit;
    assign cur_code    = {row_idx, col_idx};
    assign frame_done  = tc && (row_q == 4'b0111);
    assign frame_found = acc_found || hit;
    assign frame_code  = acc_found ? acc_code : cur_code;
    assign cnt_inc     = cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
        end else begin
            col_s1 <= bus.col;
            col_s2 <= col_s1;
        end
    end

    // Sampling at the end of the dwell leaves the synchronizer time to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell     <= '0;
            row_q     <= 4'b1110;
            acc_found <= 1'b0;
            acc_code  <= 4'd0;
        end else if (tc) begin
            dwell <= '0;
            row_q <= row_next;
            if (frame_done || !row_ok) begin
                acc_found <= 1'b0;
                acc_code  <= 4'd0;
            end else if (hit && !acc_found) begin
                acc_found <= 1'b1;
                acc_code  <= cur_code;
            end
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cand    <= 4'd0;
            cnt     <= '0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (frame_done) begin
                unique case (state)
                    IDLE: begin
                        if (frame_found) begin
                            cand  <= frame_code;
                            cnt   <= CW'(1);
                            state <= PRESS_CHK;
                        end
                    end
                    PRESS_CHK: begin
                        if (!frame_found) begin
                            state <= IDLE;
                        end else if (frame_code != cand) begin
                            cand <= frame_code;
                            cnt  <= CW'(1);
                        end else if (cnt_inc == CNT_MAX) begin
                            cnt     <= cnt_inc;
                            state   <= HELD;
                            code_q  <= cand;
                            valid_q <= 1'b1;
                            held_q  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HELD: begin
                        if (!frame_found) begin
                            cnt   <= CW'(1);
                            state <= RELEASE_CHK;
                        end
                    end
                    RELEASE_CHK: begin
                        if (frame_found) begin
                            state <= HELD;
                        end else if (cnt_inc == CNT_MAX) begin
                            cnt    <= cnt_inc;
                            state  <= IDLE;
                            held_q <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.row       = row_q;
    assign bus.key_code  = code_q;
    assign bus.key_valid = valid_q;
    assign bus.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational key-matrix model
// and a scoreboard of expected key events.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] pressed;
    int          cyc;
    int          checks;
    int          failures;
    logic [3:0]  sb[$];
    logic        prev_valid;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        kif.col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!kif.row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) kif.col[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic to_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every key_valid pulse must match a queued event.
    initial begin
        logic [3:0] exp;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) begin
                checks++;
                assert (!prev_valid) else begin
                    failures++;
                    $error("FAIL double_pulse observed=1 expected=0");
                end
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_pulse code=%h expected=none",
                           kif.key_code);
                end
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    checks++;
                    assert (kif.key_code === exp) else begin
                        failures++;
                        $error("FAIL pulse_code observed=%h expected=%h",
                               kif.key_code, exp);
                    end
                end
            end
            prev_valid = (kif.key_valid === 1'b1);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        pressed  = '0;
        rst      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_row", kif.row, 4'b1110);
        chk("reset_code", kif.key_code, 4'd0);
        chk("reset_valid", {3'd0, kif.key_valid}, 4'd0);
        chk("reset_held", {3'd0, kif.key_held}, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: idle scan
        to_edge(3);
        chk("scan_r0_hold", kif.row, 4'b1110);
        to_edge(4);
        chk("scan_r1", kif.row, 4'b1101);
        to_edge(8);
        chk("scan_r2", kif.row, 4'b1011);
        to_edge(12);
        chk("scan_r3", kif.row, 4'b0111);
        to_edge(16);
        chk("scan_wrap", kif.row, 4'b1110);
        chk("idle_held", {3'd0, kif.key_held}, 4'd0);
        chk("idle_code", kif.key_code, 4'd0);

        // 2: key 6 held 10 frames
        pressed[6] = 1'b1;
        sb.push_back(4'd6);
        to_edge(63);
        chk("k6_early_valid", {3'd0, kif.key_valid}, 4'd0);
        chk("k6_early_held", {3'd0, kif.key_held}, 4'd0);
        to_edge(64);
        chk("k6_valid", {3'd0, kif.key_valid}, 4'd1);
        chk("k6_held", {3'd0, kif.key_held}, 4'd1);
        chk("k6_code", kif.key_code, 4'd6);
        to_edge(65);
        chk("k6_pulse_end", {3'd0, kif.key_valid}, 4'd0);
        to_edge(176);
        pressed[6] = 1'b0;
        to_edge(223);
        chk("k6_rel_held", {3'd0, kif.key_held}, 4'd1);
        to_edge(224);
        chk("k6_released", {3'd0, kif.key_held}, 4'd0);
        chk("k6_code_kept", kif.key_code, 4'd6);

        // 3: bounce on key 6
        to_edge(240);
        pressed[6] = 1'b1;
        to_edge(272);
        pressed[6] = 1'b0;
        to_edge(288);
        chk("bounce_held", {3'd0, kif.key_held}, 4'd0);
        pressed[6] = 1'b1;
        sb.push_back(4'd6);
        to_edge(335);
        chk("bounce_early", {3'd0, kif.key_valid}, 4'd0);
        to_edge(336);
        chk("bounce_valid", {3'd0, kif.key_valid}, 4'd1);
        to_edge(368);
        pressed[6] = 1'b0;
        to_edge(416);
        chk("bounce_rel", {3'd0, kif.key_held}, 4'd0);

        // 4: keys 3 and 9 together
        pressed[3] = 1'b1;
        pressed[9] = 1'b1;
        sb.push_back(4'd3);
        to_edge(464);
        chk("multi_valid", {3'd0, kif.key_valid}, 4'd1);
        chk("multi_code", kif.key_code, 4'd3);
        to_edge(496);
        pressed = '0;
        to_edge(544);
        chk("multi_rel", {3'd0, kif.key_held}, 4'd0);

        // 5: key 5, short gap, then rollover to add key 12
        pressed[5] = 1'b1;
        sb.push_back(4'd5);
        to_edge(592);
        chk("k5_valid", {3'd0, kif.key_valid}, 4'd1);
        pressed[5] = 1'b0;
        to_edge(608);
        pressed[5] = 1'b1;
        to_edge(609);
        chk("k5_gap_held", {3'd0, kif.key_held}, 4'd1);
        to_edge(625);
        chk("k5_rehold", {3'd0, kif.key_held}, 4'd1);
        to_edge(640);
        pressed[12] = 1'b1;
        to_edge(700);
        chk("roll_code", kif.key_code, 4'd5);
        chk("roll_held", {3'd0, kif.key_held}, 4'd1);
        to_edge(704);
        pressed = '0;
        to_edge(751);
        chk("roll_rel_held", {3'd0, kif.key_held}, 4'd1);
        to_edge(752);
        chk("roll_released", {3'd0, kif.key_held}, 4'd0);

        // 6: reset while key 10 is held
        pressed[10] = 1'b1;
        sb.push_back(4'd10);
        to_edge(800);
        chk("k10_valid", {3'd0, kif.key_valid}, 4'd1);
        to_edge(850);
        chk("k10_held", {3'd0, kif.key_held}, 4'd1);
        rst = 1'b0;
        #1;
        chk("async_row", kif.row, 4'b1110);
        chk("async_held", {3'd0, kif.key_held}, 4'd0);
        chk("async_code", kif.key_code, 4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.push_back(4'd10);
        to_edge(47);
        chk("post_rst_early", {3'd0, kif.key_valid}, 4'd0);
        to_edge(48);
        chk("post_rst_valid", {3'd0, kif.key_valid}, 4'd1);
        chk("post_rst_code", kif.key_code, 4'd10);
        chk("post_rst_held", {3'd0, kif.key_held}, 4'd1);
        to_edge(49);
        pressed = '0;
        to_edge(100);
        chk("final_held", {3'd0, kif.key_held}, 4'd0);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL missing_pulses observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
